fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch stage with a prefetch FIFO, for the pipelined 16-bit core. It owns the program counter and issues reads to a synchronous instruction memory with one-cycle read latency. It buffers returned words with their PC and PC+step, and presents them to decode through a valid/ready handshake. A redirect from execute, a taken branch or jump, flushes buffered and in-flight words and restarts fetch at the target.

## Interface
- Clock `clk`, single clock domain. Reset `rst` is asynchronous and active-high.

Parameters
- `PC_W`, 16, PC and target width.
- `INSTR_W`, 16, instruction word width.
- `ADDR_W`, 8, instruction-memory address width; `imem_addr = fetch_pc[ADDR_W-1:0]`.
- `PC_STEP`, 2, PC increment per instruction.
- `DEPTH`, 4, FIFO entries, ≥2, power of two.
- `RESET_PC`, 0, PC value loaded on reset.

Ports
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous active-high reset.
- `imem_rd` out 1: read strobe; address is sampled by memory at the same edge.
- `imem_addr` out ADDR_W: read address.
- `imem_rdata` in INSTR_W: read data, valid in the cycle after `imem_rd`.
- `redirect_valid` in 1: execute requests a PC change (PCSrcE).
- `redirect_pc` in PC_W: redirect target.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: decode accepts the head.
- `out_instr` out INSTR_W: head instruction.
- `out_pc` out PC_W: head PC.
- `out_pc_plus` out PC_W: head PC + PC_STEP, modulo 2^PC_W.
- `perf_fetched` out 32: only with the perf macro.
- `perf_flushed` out 32: only with the perf macro.

## Operation
- State registers:
  - `fetch_pc`.
  - FIFO of {instr, pc}, with count 0..DEPTH and wrapping rd/wr pointers.
  - `inflight` (1 bit) and `inflight_pc`.
  - `drop` (1 bit).
- `pop = out_valid & out_ready`. `out_valid = (count != 0)`, a purely registered value.
- Issue condition: `!redirect_valid && (count + inflight - pop) < DEPTH`.
  - On issue: `imem_rd=1`, `inflight<=1`, `inflight_pc<=fetch_pc`, `fetch_pc<=fetch_pc+PC_STEP`.
  - With no issue, `inflight<=0`.
- Response: when `inflight` is set and `drop` is clear, push {`imem_rdata`, `inflight_pc`}. A push and a pop may occur in the same cycle; count is then unchanged.
- Redirect, when `redirect_valid`=1:
  - Count and pointers clear.
  - `fetch_pc<=redirect_pc`.
  - No issue occurs that cycle.
  - If `inflight` is set, its response is not pushed.
  - Redirect has priority over push and pop. A pop in the same cycle still completes the handshake for decode; decode is responsible for squashing it.
- Redirects may come back-to-back. Each one discards everything fetched before it.
- `fetch_pc` and `out_pc_plus` wrap modulo 2^PC_W. `imem_addr` is a plain truncation.
- FIFO never overflows: the issue condition guarantees a free slot for every in-flight response.
- Reset values: `fetch_pc=RESET_PC`, count=0, `inflight=0`, `drop=0`, `out_valid=0`, `imem_rd=0` while `rst`=1, perf counters 0.
- Reset may arrive mid-operation and discards all state immediately.

## Timing
- Read issued in cycle t. Data arrives in t+1 and is written at the end of t+1. `out_valid` rises in t+2.
- Reset released before cycle 0: first issue at `RESET_PC` in cycle 0, `out_valid`=1 in cycle 2.
- Redirect in cycle t: issue at `redirect_pc` in t+1, `out_valid`=0 during t+1..t+2, target visible in t+3. The redirect-to-instruction penalty is 3 cycles.
- With `out_ready` held at 1, one instruction per cycle is sustained for any DEPTH ≥ 2.
- With `out_ready`=0 and the FIFO full, `imem_rd` stays 0 and the outputs hold stable.
- All outputs except `imem_rd`/`imem_addr` are registered. `imem_rd` depends combinationally on `redirect_valid` and `out_ready`.

## Configuration
- `FETCH_PERF_EN` defined:
  - Adds `perf_fetched`, incremented on each pop.
  - Adds `perf_flushed`, incremented on a redirect by count + (inflight & !pop-ignored), i.e. the entries and in-flight word discarded.
  - Both counters saturate at 2^32−1.
- `FETCH_PERF_EN` undefined: the perf ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then `out_ready`=1, with memory holding word k = 16'hA000+k: `out_valid` rises in cycle 2. Outputs are (A000, pc 0, plus 2), (A001, 2, 4), … one per cycle.
- `out_ready`=0 for 10 cycles with DEPTH=4: exactly 4 reads are issued. `imem_rd` then stays 0 and `out_instr` holds A000. Releasing `out_ready` resumes one instruction per cycle with no gap.
- Redirect to 16'h0040 while the FIFO holds 3 entries and a read is in flight: the next valid output is pc 0x0040, 3 cycles after the redirect. None of the old words appear. `perf_flushed` increases by 4.
- Back-to-back redirects to 0x0010 then 0x0020: only pc 0x0020 and its successors appear.
- `RESET_PC`=16'hFFFE: outputs are pc FFFE with plus 0000, then pc 0000. `imem_addr` reads FE, then 00.
- Assert `rst` mid-stream with the FIFO full: `out_valid`=0 immediately. Fetch restarts at `RESET_PC` after release.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-cycle-latency reads and buffers returned words for decode.
// Optional FETCH_PERF_EN adds saturating fetched/flushed performance counters.
module fetch_unit #(
  parameter int unsigned    PC_W     = 16,
  parameter int unsigned    INSTR_W  = 16,
  parameter int unsigned    ADDR_W   = 8,
  parameter int unsigned    PC_STEP  = 2,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_rd,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_pc_plus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_flushed
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus;
  } entry_t;

  entry_t            fifo [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [PC_W-1:0]   fetch_pc, inflight_pc;
  logic              inflight, drop;
  logic              pop, push, issue;
  logic [CNT_W:0]    occupancy;

  assign out_valid   = (count != '0);
  assign pop         = out_valid & out_ready;
  // Slots already committed once this cycle's pop leaves; an issue needs one free.
  assign occupancy   = (CNT_W+1)'(count) + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
  assign issue       = !rst && !redirect_valid && (occupancy < (CNT_W+1)'(DEPTH));
  assign push        = inflight && !drop && !redirect_valid;
  assign imem_rd     = issue;
  assign imem_addr   = fetch_pc[ADDR_W-1:0];

  assign out_instr   = fifo[rd_ptr].instr;
  assign out_pc      = fifo[rd_ptr].pc;
  assign out_pc_plus = fifo[rd_ptr].pc_plus;

  // FIFO storage carries no reset; count alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= '{instr: imem_rdata, pc: inflight_pc,
                         pc_plus: inflight_pc + PC_W'(PC_STEP)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      drop        <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      drop     <= redirect_valid;
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
      end
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (issue) fetch_pc <= fetch_pc + PC_W'(PC_STEP);
        if (push)  wr_ptr   <= wr_ptr + PTR_W'(1);
        if (pop)   rd_ptr   <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (!push && pop) count <= count - CNT_W'(1);
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [32:0] flushed_sum;

  assign flushed_sum = {1'b0, perf_flushed} + 33'(count) + 33'(inflight);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
      if (redirect_valid) perf_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one DEPTH=4 instance at PC 0 and one DEPTH=2 instance at PC FFFE.
module tb_fetch_unit;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, redir_a, ready_a, rd_a, valid_a;
  logic [15:0] rpc_a, rdata_a, instr_a, pc_a, plus_a;
  logic [7:0]  addr_a;
  logic        rst_b, redir_b, ready_b, rd_b, valid_b;
  logic [15:0] rpc_b, rdata_b, instr_b, pc_b, plus_b;
  logic [7:0]  addr_b;
`ifdef FETCH_PERF_EN
  logic [31:0] fetched_a, flushed_a, fetched_b, flushed_b;
  logic [31:0] flushed0;
`endif

  int checks = 0;
  int passed = 0;
  int reads;

  fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut_a (
    .clk(clk), .rst(rst_a), .imem_rd(rd_a), .imem_addr(addr_a), .imem_rdata(rdata_a),
    .redirect_valid(redir_a), .redirect_pc(rpc_a), .out_valid(valid_a), .out_ready(ready_a),
    .out_instr(instr_a), .out_pc(pc_a), .out_pc_plus(plus_a)
`ifdef FETCH_PERF_EN
    , .perf_fetched(fetched_a), .perf_flushed(flushed_a)
`endif
  );

  fetch_unit #(.DEPTH(2), .RESET_PC(16'hFFFE)) dut_b (
    .clk(clk), .rst(rst_b), .imem_rd(rd_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
    .redirect_valid(redir_b), .redirect_pc(rpc_b), .out_valid(valid_b), .out_ready(ready_b),
    .out_instr(instr_b), .out_pc(pc_b), .out_pc_plus(plus_b)
`ifdef FETCH_PERF_EN
    , .perf_fetched(fetched_b), .perf_flushed(flushed_b)
`endif
  );

  // Word k sits at byte address 2k and holds A000+k.
  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return 16'hA000 + 16'(a >> 1);
  endfunction

  always_ff @(posedge clk) begin
    if (rd_a) rdata_a <= mem_word(addr_a);
    if (rd_b) rdata_b <= mem_word(addr_b);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic check_head_a(input string tag, input logic [15:0] pc);
    check({tag, "_valid"}, 32'(valid_a), 32'd1);
    check({tag, "_pc"}, 32'(pc_a), 32'(pc));
    check({tag, "_plus"}, 32'(plus_a), 32'(pc + 16'd2));
    check({tag, "_instr"}, 32'(instr_a), 32'(mem_word(pc[7:0])));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; redir_a = 1'b0; rpc_a = '0; ready_a = 1'b1;
    rst_b = 1'b1; redir_b = 1'b0; rpc_b = '0; ready_b = 1'b1;
    repeat (3) tick;
    check("rst_rd", 32'(rd_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);

    // Streaming from reset with decode always ready
    rst_a = 1'b0; #1;
    check("c0_rd", 32'(rd_a), 32'd1);
    check("c0_addr", 32'(addr_a), 32'h00);
    check("c0_valid", 32'(valid_a), 32'd0);
    tick;
    check("c1_valid", 32'(valid_a), 32'd0);
    check("c1_addr", 32'(addr_a), 32'h02);
    for (int k = 0; k < 5; k++) begin
      tick;
      check_head_a("stream", 16'(2 * k));
    end

    // Backpressure fills the FIFO with exactly DEPTH reads
    ready_a = 1'b0; rst_a = 1'b1;
    tick;
    rst_a = 1'b0; #1;
    reads = 0;
    for (int i = 0; i < 10; i++) begin
      if (rd_a) reads++;
      tick;
    end
    check("bp_reads", 32'(reads), 32'd4);
    check("bp_rd_idle", 32'(rd_a), 32'd0);
    check("bp_hold_valid", 32'(valid_a), 32'd1);
    check("bp_hold_instr", 32'(instr_a), 32'hA000);
    ready_a = 1'b1; #1;
    for (int i = 0; i < 8; i++) begin
      check_head_a("resume", 16'(2 * i));
      tick;
    end

    // Redirect with 3 buffered entries and one read in flight
    ready_a = 1'b0; rst_a = 1'b1;
    tick;
    rst_a = 1'b0; #1;
    repeat (4) tick;
    check("pre_redir_valid", 32'(valid_a), 32'd1);
    check("pre_redir_rd", 32'(rd_a), 32'd0);
`ifdef FETCH_PERF_EN
    flushed0 = flushed_a;
`endif
    redir_a = 1'b1; rpc_a = 16'h0040; #1;
    check("redir_rd", 32'(rd_a), 32'd0);
    tick;
    redir_a = 1'b0; #1;
    check("redir_t1_valid", 32'(valid_a), 32'd0);
    check("redir_t1_rd", 32'(rd_a), 32'd1);
    check("redir_t1_addr", 32'(addr_a), 32'h40);
`ifdef FETCH_PERF_EN
    check("perf_flushed", flushed_a, flushed0 + 32'd4);
    check("perf_fetched_0", fetched_a, 32'd0);
`endif
    tick;
    check("redir_t2_valid", 32'(valid_a), 32'd0);
    tick;
    check_head_a("redir_t3", 16'h0040);
    ready_a = 1'b1;
    tick;
    check_head_a("redir_next", 16'h0042);
    tick;
    check_head_a("redir_next2", 16'h0044);
`ifdef FETCH_PERF_EN
    check("perf_fetched_2", fetched_a, 32'd2);
`endif

    // Back-to-back redirects: only the second target survives
    redir_a = 1'b1; rpc_a = 16'h0010;
    tick;
    rpc_a = 16'h0020; #1;
    check("b2b_t1_valid", 32'(valid_a), 32'd0);
    tick;
    redir_a = 1'b0; #1;
    check("b2b_t2_valid", 32'(valid_a), 32'd0);
    check("b2b_t2_addr", 32'(addr_a), 32'h20);
    tick;
    check("b2b_t3_valid", 32'(valid_a), 32'd0);
    tick;
    check_head_a("b2b_head", 16'h0020);
    tick;
    check_head_a("b2b_next", 16'h0022);
    tick;
    check_head_a("b2b_next2", 16'h0024);

    // Asynchronous reset while full
    ready_a = 1'b0;
    repeat (6) tick;
    check("full_valid", 32'(valid_a), 32'd1);
    check("full_rd", 32'(rd_a), 32'd0);
    rst_a = 1'b1; #1;
    check("mid_rst_valid", 32'(valid_a), 32'd0);
    check("mid_rst_rd", 32'(rd_a), 32'd0);
    ready_a = 1'b1;
    tick;
    rst_a = 1'b0; #1;
    check("restart_addr", 32'(addr_a), 32'h00);
    check("restart_rd", 32'(rd_a), 32'd1);
    tick;
    tick;
    check_head_a("restart_head", 16'h0000);

    // PC wrap from FFFE, DEPTH=2 throughput
    rst_b = 1'b0; #1;
    check("wrap_c0_rd", 32'(rd_b), 32'd1);
    check("wrap_c0_addr", 32'(addr_b), 32'hFE);
    check("wrap_c0_valid", 32'(valid_b), 32'd0);
    tick;
    check("wrap_c1_addr", 32'(addr_b), 32'h00);
    tick;
    check("wrap_pc0", 32'(pc_b), 32'hFFFE);
    check("wrap_plus0", 32'(plus_b), 32'h0000);
    check("wrap_instr0", 32'(instr_b), 32'hA07F);
    for (int k = 0; k < 4; k++) begin
      tick;
      check("d2_valid", 32'(valid_b), 32'd1);
      check("d2_pc", 32'(pc_b), 32'(2 * k));
      check("d2_plus", 32'(plus_b), 32'(2 * k + 2));
      check("d2_instr", 32'(instr_b), 32'(16'hA000 + 16'(k)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
